sp_bank_scheduler: RTL and testbench
====================================

SP_BANK_SCHEDULER -- requirements
Module: sp_bank_scheduler

Interface
REQ-001 SHALL take parameter MAT_S_W, default 2, matrix-select width.
REQ-002 SHALL take parameter ROW_S_W, default 2, row-select width; 4 rows per matrix.
REQ-003 SHALL take parameter BITS_PER_ROW, default 64, row data width.
REQ-004 SHALL take parameter ADDR_W, default 32, DRAM byte-address width.
REQ-005 SHALL have port CLK  in  1  clock; all state changes on posedge.
REQ-006 SHALL have port nRST  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 SHALL have port cmd_op  in  2  command: 01 STORE, 10 GEMM, 00/11 NOP.
REQ-009 SHALL have port cmd_addr  in  ADDR_W  STORE base DRAM address.
REQ-010 SHALL have port cmd_mat_a, cmd_mat_b, cmd_mat_c  in  MAT_S_W each  operand matrix selects.
REQ-011 SHALL have port ld_valid / ld_ready  in / out  1 / 1  DRAM-load row write request.
REQ-012 SHALL have port ld_mat_s, ld_row_s, ld_data  in  MAT_S_W, ROW_S_W, BITS_PER_ROW  load row payload.
REQ-013 SHALL have port res_valid / res_ready  in / out  1 / 1  GEMM-result row write request.
REQ-014 SHALL have port res_mat_s, res_row_s, res_data  in  MAT_S_W, ROW_S_W, BITS_PER_ROW  result row payload.
REQ-015 SHALL have port wFIFO_WEN / wFIFO_wdata / wFIFO_full  out / out / in  1 / wFIFO_t / 1  bank write queue.
REQ-016 SHALL have port rFIFO_WEN / rFIFO_wdata / rFIFO_full  out / out / in  1 / rFIFO_t / 1  bank read queue.
REQ-017 SHALL have port busy  out  1  high whenever FSM not IDLE.

Function
REQ-018 SHALL implement read-issue FSM with states IDLE, STORE_RD, GEMM_RD.
REQ-019 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-020 SHALL on accepted STORE latch mat_a and cmd_addr, clear 4-bit counter, go STORE_RD.
REQ-021 SHALL on accepted GEMM latch mat_a/b/c, clear counter, go GEMM_RD.
REQ-022 SHALL on accepted NOP (00/11) remain IDLE, issue nothing.
REQ-023 SHALL in STORE_RD, each cycle rFIFO_full==0, assert rFIFO_WEN with mat_t=00, mat_s=latched A, row_s=cnt[1:0], addr=base+8*cnt (mod 2^ADDR_W), then increment cnt.
REQ-024 SHALL in GEMM_RD issue 12 reads in order A rows 0..3 (mat_t=01), B rows 0..3 (mat_t=10), C rows 0..3 (mat_t=11); addr field 0.
REQ-025 SHALL hold rFIFO_WEN=0 and counter unchanged while rFIFO_full==1.
REQ-026 SHALL return to IDLE on the cycle after the last read issues (cnt 3 STORE, 11 GEMM); first read issues the cycle after acceptance.
REQ-027 SHALL arbitrate ld and res requesters into wFIFO, at most one write per cycle, only when wFIFO_full==0.
REQ-028 SHALL use round-robin: on contention grant the requester not granted last; priority pointer resets to ld-first.
REQ-029 SHALL assert ld_ready/res_ready combinationally only for the granted requester; wFIFO_WEN equals the grant.
REQ-030 SHALL pack wFIFO_wdata as {gemm_result, mat_s, row_s, data}, gemm_result=1 for res, 0 for ld.
REQ-031 SHALL run write arbitration independently of and concurrently with read FSM.
REQ-032 SHALL hold all ready/WEN outputs at 0 when wFIFO_full/rFIFO_full respectively asserted.

Reset
REQ-033 SHALL on nRST low: FSM=IDLE, counter=0, latched fields=0, RR pointer=ld-first, busy=0, rFIFO_WEN=0.
REQ-034 SHALL abandon any in-progress command on reset; no partial-sequence resumption.

Structure
REQ-035 SHALL source wFIFO_t, rFIFO_t, MAT_S_W, ROW_S_W, BITS_PER_ROW from sp_types_pkg; FSM state enum and cmd_op encodings added there.
REQ-036 SHALL factor the two-way round-robin into sub-module sp_rr_arb2.

Verification
REQ-037 SHALL verify STORE mat_a=2, addr=0x1000, rFIFO_full=0 -> 4 writes cycles 1..4: rows 0..3, addr 0x1000/1008/1010/1018, mat_t=00; cmd_ready high cycle 5.
REQ-038 SHALL verify GEMM a=0,b=1,c=3 with rFIFO_full high cycles 3..5 -> 12 writes, mat_t sequence 01x4,10x4,11x4, no loss, done 3 cycles late.
REQ-039 SHALL verify ld_valid and res_valid held high 4 cycles -> grants ld,res,ld,res; gemm_result bits 0,1,0,1.
REQ-040 SHALL verify wFIFO_full high with both valid -> both readies 0, wFIFO_WEN 0.
REQ-041 SHALL verify STORE addr=0xFFFFFFF8 -> second row addr 0x00000000.
REQ-042 SHALL verify nRST asserted after 6 of 12 GEMM reads -> busy=0, cmd_ready=1 after release, no further rFIFO_WEN.

Source files
------------

// File: rtl/sp_types_pkg.sv
// Shared scratchpad types: bank FIFO entry layouts, command opcodes and
// the read-issue FSM encoding used by the bank scheduler.
package sp_types_pkg;
    localparam int MAT_S_W      = 2;
    localparam int ROW_S_W      = 2;
    localparam int BITS_PER_ROW = 64;
    localparam int ADDR_W       = 32;

    // Any opcode other than these two is treated as a NOP.
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_GEMM  = 2'b10;

    // STORE reads tag rows 00; GEMM operands A/B/C tag 01/10/11.
    localparam logic [1:0] MT_STORE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STORE_RD = 2'd1,
        ST_GEMM_RD  = 2'd2
    } state_e;

    typedef struct packed {
        logic                    gemm_result;
        logic [MAT_S_W-1:0]      mat_s;
        logic [ROW_S_W-1:0]      row_s;
        logic [BITS_PER_ROW-1:0] data;
    } wFIFO_t;

    typedef struct packed {
        logic [1:0]         mat_t;
        logic [MAT_S_W-1:0] mat_s;
        logic [ROW_S_W-1:0] row_s;
        logic [ADDR_W-1:0]  addr;
    } rFIFO_t;
endpackage

// File: rtl/sp_rr_arb2.sv
// Two-way round-robin arbiter; req[0] wins contention first after reset.
module sp_rr_arb2 (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // prio_q == 0 favours req[0] on contention, 1 favours req[1].
    logic prio_q, prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (en) begin
            if (req[0] && (!req[1] || !prio_q)) gnt = 2'b01;
            else if (req[1])                     gnt = 2'b10;
        end
        if (gnt[0])      prio_d = 1'b1;
        else if (gnt[1]) prio_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end
endmodule

// File: rtl/sp_bank_scheduler.sv
// Scratchpad bank scheduler: read-issue FSM for STORE/GEMM commands into the
// bank read queue, plus round-robin merge of load and result rows into the write queue.
module sp_bank_scheduler
    import sp_types_pkg::*;
#(
    parameter int MAT_S_W      = sp_types_pkg::MAT_S_W,
    parameter int ROW_S_W      = sp_types_pkg::ROW_S_W,
    parameter int BITS_PER_ROW = sp_types_pkg::BITS_PER_ROW,
    parameter int ADDR_W       = sp_types_pkg::ADDR_W
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [MAT_S_W-1:0]      cmd_mat_a,
    input  logic [MAT_S_W-1:0]      cmd_mat_b,
    input  logic [MAT_S_W-1:0]      cmd_mat_c,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [MAT_S_W-1:0]      ld_mat_s,
    input  logic [ROW_S_W-1:0]      ld_row_s,
    input  logic [BITS_PER_ROW-1:0] ld_data,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [MAT_S_W-1:0]      res_mat_s,
    input  logic [ROW_S_W-1:0]      res_row_s,
    input  logic [BITS_PER_ROW-1:0] res_data,
    output logic                    wFIFO_WEN,
    output wFIFO_t                  wFIFO_wdata,
    input  logic                    wFIFO_full,
    output logic                    rFIFO_WEN,
    output rFIFO_t                  rFIFO_wdata,
    input  logic                    rFIFO_full,
    output logic                    busy
);
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MAT_S_W-1:0]  mat_a_q, mat_a_d, mat_b_q, mat_b_d, mat_c_q, mat_c_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          gnt;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
        mat_c_d     = mat_c_q;
        base_d      = base_q;
        cmd_ready   = (state_q == ST_IDLE);
        rFIFO_WEN   = 1'b0;
        rFIFO_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_op == OP_STORE) begin
                    mat_a_d = cmd_mat_a;
                    base_d  = cmd_addr;
                    cnt_d   = '0;
                    state_d = ST_STORE_RD;
                end else if (cmd_valid && cmd_op == OP_GEMM) begin
                    mat_a_d = cmd_mat_a;
                    mat_b_d = cmd_mat_b;
                    mat_c_d = cmd_mat_c;
                    cnt_d   = '0;
                    state_d = ST_GEMM_RD;
                end
            end
            ST_STORE_RD: begin
                if (!rFIFO_full) begin
                    rFIFO_WEN         = 1'b1;
                    rFIFO_wdata.mat_t = MT_STORE;
                    rFIFO_wdata.mat_s = mat_a_q;
                    rFIFO_wdata.row_s = cnt_q[1:0];
                    rFIFO_wdata.addr  = base_q + ADDR_W'({cnt_q, 3'b000});
                    cnt_d             = cnt_q + 4'd1;
                    if (cnt_q == 4'd3) state_d = ST_IDLE;
                end
            end
            ST_GEMM_RD: begin
                // cnt[3:2] walks operand A, B, C; cnt[1:0] walks the rows.
                if (!rFIFO_full) begin
                    rFIFO_WEN         = 1'b1;
                    rFIFO_wdata.mat_t = cnt_q[3:2] + 2'd1;
                    case (cnt_q[3:2])
                        2'd0:    rFIFO_wdata.mat_s = mat_a_q;
                        2'd1:    rFIFO_wdata.mat_s = mat_b_q;
                        default: rFIFO_wdata.mat_s = mat_c_q;
                    endcase
                    rFIFO_wdata.row_s = cnt_q[1:0];
                    cnt_d             = cnt_q + 4'd1;
                    if (cnt_q == 4'd11) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            mat_c_q <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            mat_c_q <= mat_c_d;
            base_q  <= base_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    sp_rr_arb2 u_arb (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (!wFIFO_full),
        .req  ({res_valid, ld_valid}),
        .gnt  (gnt)
    );

    assign ld_ready  = gnt[0];
    assign res_ready = gnt[1];
    assign wFIFO_WEN = |gnt;

    always_comb begin
        wFIFO_wdata.gemm_result = gnt[1];
        wFIFO_wdata.mat_s       = gnt[1] ? res_mat_s : ld_mat_s;
        wFIFO_wdata.row_s       = gnt[1] ? res_row_s : ld_row_s;
        wFIFO_wdata.data        = gnt[1] ? res_data  : ld_data;
    end
endmodule

// File: tb/tb_sp_bank_scheduler.sv
// Self-checking bench for sp_bank_scheduler: directed scenarios plus a
// randomized mix checked against a queue/arithmetic reference model.
module tb_sp_bank_scheduler;
    import sp_types_pkg::*;

    logic                    CLK = 1'b0;
    logic                    nRST;
    logic                    cmd_valid, cmd_ready;
    logic [1:0]              cmd_op;
    logic [ADDR_W-1:0]       cmd_addr;
    logic [MAT_S_W-1:0]      cmd_mat_a, cmd_mat_b, cmd_mat_c;
    logic                    ld_valid, ld_ready, res_valid, res_ready;
    logic [MAT_S_W-1:0]      ld_mat_s, res_mat_s;
    logic [ROW_S_W-1:0]      ld_row_s, res_row_s;
    logic [BITS_PER_ROW-1:0] ld_data, res_data;
    logic                    wFIFO_WEN, wFIFO_full, rFIFO_WEN, rFIFO_full, busy;
    wFIFO_t                  wFIFO_wdata;
    rFIFO_t                  rFIFO_wdata;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     rr_next = 0;   // model: 0 -> ld wins next contention, 1 -> res
    rFIFO_t rd_obs[$];
    rFIFO_t exp_q[$];

    sp_bank_scheduler dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_mat_a(cmd_mat_a), .cmd_mat_b(cmd_mat_b), .cmd_mat_c(cmd_mat_c),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_mat_s(ld_mat_s), .ld_row_s(ld_row_s), .ld_data(ld_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_mat_s(res_mat_s), .res_row_s(res_row_s), .res_data(res_data),
        .wFIFO_WEN(wFIFO_WEN), .wFIFO_wdata(wFIFO_wdata), .wFIFO_full(wFIFO_full),
        .rFIFO_WEN(rFIFO_WEN), .rFIFO_wdata(rFIFO_wdata), .rFIFO_full(rFIFO_full),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (nRST && rFIFO_WEN) rd_obs.push_back(rFIFO_wdata);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: the read-queue entries a command must produce.
    task automatic model_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                             input logic [MAT_S_W-1:0] a, b, c);
        rFIFO_t r;
        logic [MAT_S_W-1:0] sel[3];
        sel[0] = a; sel[1] = b; sel[2] = c;
        if (op == 2'b01) begin
            for (int k = 0; k < 4; k++) begin
                r.mat_t = 2'b00; r.mat_s = a; r.row_s = ROW_S_W'(k);
                r.addr  = addr + ADDR_W'(8 * k);
                exp_q.push_back(r);
            end
        end else if (op == 2'b10) begin
            for (int m = 0; m < 3; m++)
                for (int k = 0; k < 4; k++) begin
                    r.mat_t = 2'(m + 1); r.mat_s = sel[m]; r.row_s = ROW_S_W'(k);
                    r.addr  = '0;
                    exp_q.push_back(r);
                end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents a command once cmd_ready is up; returns at cycle 1 after acceptance.
    task automatic issue_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                             input logic [MAT_S_W-1:0] a, b, c);
        int w = 0;
        while (!cmd_ready && w < 50) begin tick(); w++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cmd_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
        cmd_mat_a = a; cmd_mat_b = b; cmd_mat_c = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_mat_a = 0; cmd_mat_b = 0; cmd_mat_c = 0;
        ld_valid = 0; ld_mat_s = 0; ld_row_s = 0; ld_data = 0;
        res_valid = 0; res_mat_s = 0; res_row_s = 0; res_data = 0;
        wFIFO_full = 0; rFIFO_full = 0;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || rFIFO_WEN !== 1'b0 || wFIFO_WEN !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b cmd_ready=%b rWEN=%b wWEN=%b required 0 1 0 0",
                     busy, cmd_ready, rFIFO_WEN, wFIFO_WEN);
        end
        nRST = 1'b1;
        rr_next = 0;
        tick();
    endtask

    task automatic test_store();
        rd_obs.delete(); exp_q.delete();
        model_cmd(2'b01, 32'h1000, 2'd2, 2'd0, 2'd0);
        issue_cmd(2'b01, 32'h1000, 2'd2, 2'd0, 2'd0);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge CLK);
            n_cmp++;
            if (cyc <= 4) begin
                if (rFIFO_WEN !== 1'b1 || busy !== 1'b1 || rFIFO_wdata !== exp_q[cyc-1]) begin
                    n_bad++;
                    $display("FAIL store_row%0d: wen=%b busy=%b data=%h required 1 1 %h",
                             cyc - 1, rFIFO_WEN, busy, rFIFO_wdata, exp_q[cyc-1]);
                end
            end else if (cmd_ready !== 1'b1 || busy !== 1'b0 || rFIFO_WEN !== 1'b0) begin
                n_bad++;
                $display("FAIL store_done: cmd_ready=%b busy=%b wen=%b required 1 0 0",
                         cmd_ready, busy, rFIFO_WEN);
            end
            tick();
        end
    endtask

    task automatic test_gemm_stall();
        int done_cyc = -1;
        rd_obs.delete(); exp_q.delete();
        model_cmd(2'b10, '0, 2'd0, 2'd1, 2'd3);
        issue_cmd(2'b10, '0, 2'd0, 2'd1, 2'd3);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            rFIFO_full = (cyc >= 3 && cyc <= 5);
            @(negedge CLK);
            if (rFIFO_full) begin
                n_cmp++;
                if (rFIFO_WEN !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gemm_stall_c%0d: wen=%b required 0", cyc, rFIFO_WEN);
                end
            end
            if (cmd_ready && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        rFIFO_full = 1'b0;
        n_cmp++;
        if (done_cyc != 16) begin
            n_bad++;
            $display("FAIL gemm_done_cycle: got %0d required 16", done_cyc);
        end
        n_cmp++;
        if (rd_obs.size() != 12) begin
            n_bad++;
            $display("FAIL gemm_count: got %0d required 12", rd_obs.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if (rd_obs[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL gemm_read%0d: got %h required %h", i, rd_obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_rr();
        wFIFO_t ew;
        int g;
        for (int cyc = 0; cyc < 4; cyc++) begin
            ld_valid = 1; res_valid = 1;
            ld_mat_s = 2'($urandom); ld_row_s = 2'($urandom); ld_data = {$urandom, $urandom};
            res_mat_s = 2'($urandom); res_row_s = 2'($urandom); res_data = {$urandom, $urandom};
            @(negedge CLK);
            g = rr_next;
            ew.gemm_result = (g == 1);
            ew.mat_s = g ? res_mat_s : ld_mat_s;
            ew.row_s = g ? res_row_s : ld_row_s;
            ew.data  = g ? res_data : ld_data;
            n_cmp++;
            if (ld_ready !== (g == 0) || res_ready !== (g == 1) || wFIFO_WEN !== 1'b1 ||
                wFIFO_wdata !== ew || wFIFO_wdata.gemm_result !== cyc[0]) begin
                n_bad++;
                $display("FAIL rr_c%0d: ldr=%b resr=%b wen=%b data=%h required grant=%0d data=%h",
                         cyc, ld_ready, res_ready, wFIFO_WEN, wFIFO_wdata, g, ew);
            end
            rr_next = 1 - g;
            tick();
        end
    endtask

    task automatic test_wfull();
        wFIFO_full = 1; ld_valid = 1; res_valid = 1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge CLK);
            n_cmp++;
            if (ld_ready !== 1'b0 || res_ready !== 1'b0 || wFIFO_WEN !== 1'b0) begin
                n_bad++;
                $display("FAIL wfull_c%0d: ldr=%b resr=%b wen=%b required 0 0 0",
                         cyc, ld_ready, res_ready, wFIFO_WEN);
            end
            tick();
        end
        wFIFO_full = 0;
        @(negedge CLK);
        n_cmp++;
        if (ld_ready !== (rr_next == 0) || res_ready !== (rr_next == 1)) begin
            n_bad++;
            $display("FAIL wfull_resume: ldr=%b resr=%b required winner %0d", ld_ready, res_ready, rr_next);
        end
        rr_next = 1 - rr_next;
        tick();
        ld_valid = 0; res_valid = 0;
    endtask

    task automatic test_addr_wrap();
        logic [MAT_S_W-1:0] a;
        a = 2'($urandom);
        rd_obs.delete(); exp_q.delete();
        model_cmd(2'b01, 32'hFFFF_FFF8, a, 2'd0, 2'd0);
        issue_cmd(2'b01, 32'hFFFF_FFF8, a, 2'd0, 2'd0);
        repeat (6) tick();
        n_cmp++;
        if (rd_obs.size() != 4) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d required 4", rd_obs.size());
        end else begin
            n_cmp++;
            if (rd_obs[1].addr !== 32'h0000_0000) begin
                n_bad++;
                $display("FAIL wrap_row1_addr: got %h required 00000000", rd_obs[1].addr);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_obs[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL wrap_read%0d: got %h required %h", i, rd_obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        wFIFO_t ew;
        int g;
        int w;
        rd_obs.delete(); exp_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op = 2'($urandom); cmd_addr = $urandom;
            cmd_mat_a = 2'($urandom); cmd_mat_b = 2'($urandom); cmd_mat_c = 2'($urandom);
            rFIFO_full = ($urandom_range(0, 3) == 0);
            wFIFO_full = ($urandom_range(0, 4) == 0);
            ld_valid = 1'($urandom); res_valid = 1'($urandom);
            ld_mat_s = 2'($urandom); ld_row_s = 2'($urandom); ld_data = {$urandom, $urandom};
            res_mat_s = 2'($urandom); res_row_s = 2'($urandom); res_data = {$urandom, $urandom};
            @(negedge CLK);
            if (cmd_valid && cmd_ready) model_cmd(cmd_op, cmd_addr, cmd_mat_a, cmd_mat_b, cmd_mat_c);
            n_cmp++;
            if (busy !== !cmd_ready) begin
                n_bad++;
                $display("FAIL rnd_busy_c%0d: busy=%b cmd_ready=%b required complementary", cyc, busy, cmd_ready);
            end
            g = -1;
            if (!wFIFO_full) begin
                if (ld_valid && res_valid) g = rr_next;
                else if (ld_valid)         g = 0;
                else if (res_valid)        g = 1;
            end
            n_cmp++;
            if (ld_ready !== (g == 0) || res_ready !== (g == 1) || wFIFO_WEN !== (g >= 0)) begin
                n_bad++;
                $display("FAIL rnd_grant_c%0d: ldr=%b resr=%b wen=%b required grant %0d",
                         cyc, ld_ready, res_ready, wFIFO_WEN, g);
            end
            if (g >= 0) begin
                ew.gemm_result = (g == 1);
                ew.mat_s = g ? res_mat_s : ld_mat_s;
                ew.row_s = g ? res_row_s : ld_row_s;
                ew.data  = g ? res_data : ld_data;
                n_cmp++;
                if (wFIFO_wdata !== ew) begin
                    n_bad++;
                    $display("FAIL rnd_wdata_c%0d: got %h required %h", cyc, wFIFO_wdata, ew);
                end
                rr_next = 1 - g;
            end
            tick();
        end
        cmd_valid = 0; rFIFO_full = 0; wFIFO_full = 0; ld_valid = 0; res_valid = 0;
        w = 0;
        while (!cmd_ready && w < 40) begin tick(); w++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rnd_drain: cmd_ready=%b required 1", cmd_ready);
        end
        n_cmp++;
        if (rd_obs.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rnd_read_count: got %0d required %0d", rd_obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (rd_obs[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rnd_read%0d: got %h required %h", i, rd_obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rd_obs.delete(); exp_q.delete();
        issue_cmd(2'b10, '0, 2'd1, 2'd2, 2'd3);
        repeat (6) begin @(negedge CLK); tick(); end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rFIFO_WEN !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_assert: busy=%b wen=%b required 0 0", busy, rFIFO_WEN);
        end
        n_cmp++;
        if (rd_obs.size() != 6) begin
            n_bad++;
            $display("FAIL midrst_reads_before: got %0d required 6", rd_obs.size());
        end
        repeat (2) tick();
        nRST = 1'b1;
        rr_next = 0;
        @(negedge CLK);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        repeat (15) tick();
        n_cmp++;
        if (rd_obs.size() != 6) begin
            n_bad++;
            $display("FAIL midrst_no_resume: got %0d reads required 6", rd_obs.size());
        end
        ld_valid = 1; res_valid = 1;
        @(negedge CLK);
        n_cmp++;
        if (ld_ready !== 1'b1 || res_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_rr_ptr: ldr=%b resr=%b required 1 0", ld_ready, res_ready);
        end
        tick();
        ld_valid = 0; res_valid = 0;
    endtask

    initial begin
        test_reset();
        test_store();
        test_gemm_stall();
        test_rr();
        test_wfull();
        test_addr_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
